matrix_upsample: RTL and testbench

MATRIX_UPSAMPLE -- requirements
Module: matrix_upsample

---
 rtl/matrix_upsample.sv | 164 ++++++++++++++++
 tb/tb_matrix_upsample.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_upsample.sv
// Nearest-neighbour matrix upsampler: reads an R x C source matrix and writes an
// (R*K) x (C*K) destination, re-fetching each source row once per output row.
module matrix_upsample (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  input  logic [13:0]        src_start_address,
  output logic [13:0]        src_address,
  input  logic signed [15:0] src_readdata,
  output logic               src_write_en,
  input  logic [5:0]         src_row_size,
  input  logic [5:0]         src_col_size,
  input  logic [3:0]         scale,
  input  logic [13:0]        dest_start_address,
  output logic [13:0]        dest_address,
  output logic signed [15:0] dest_writedata,
  output logic               dest_write_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         rows_q, rows_d;
  logic [5:0]         cols_q, cols_d;
  logic [3:0]         k_q, k_d;
  logic               zero_q, zero_d;
  logic [13:0]        row_base_q, row_base_d;
  logic [13:0]        src_addr_q, src_addr_d;
  logic [13:0]        dest_addr_q, dest_addr_d;
  logic signed [15:0] data_q, data_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  // sy/ky: source row and sub-row within it; c: source column; kx: write within WRITE
  logic [5:0]         sy_q, sy_d;
  logic [3:0]         ky_q, ky_d;
  logic [5:0]         c_q, c_d;
  logic [3:0]         kx_q, kx_d;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    k_d         = k_q;
    zero_d      = zero_q;
    row_base_d  = row_base_q;
    src_addr_d  = src_addr_q;
    dest_addr_d = dest_addr_q;
    data_d      = data_q;
    sy_d        = sy_q;
    ky_d        = ky_q;
    c_d         = c_q;
    kx_d        = kx_q;

    case (state_q)
      S_IDLE: begin
        src_addr_d  = src_start_address;
        dest_addr_d = dest_start_address;
        row_base_d  = src_start_address;
        if (start) begin
          rows_d  = src_row_size;
          cols_d  = src_col_size;
          k_d     = (scale > 4'd8) ? 4'd8 : scale;
          zero_d  = (src_row_size == 6'd0) || (src_col_size == 6'd0) || (scale == 4'd0);
          sy_d    = '0;
          ky_d    = '0;
          c_d     = '0;
          kx_d    = '0;
          state_d = S_ADDR;
        end
      end
      // An empty operation still spends one cycle out of IDLE so done visibly pulses low.
      S_ADDR:  state_d = zero_q ? S_IDLE : S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD: begin
        data_d  = src_readdata;
        kx_d    = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Destination writes are strictly row-major, so the write pointer only increments.
        dest_addr_d = dest_addr_q + 14'd1;
        if (kx_q == k_q - 4'd1) begin
          state_d = S_ADDR;
          if (c_q == cols_q - 6'd1) begin
            c_d = '0;
            if (ky_q == k_q - 4'd1) begin
              if (sy_q == rows_q - 6'd1) begin
                state_d = S_IDLE;
              end else begin
                ky_d       = '0;
                sy_d       = sy_q + 6'd1;
                row_base_d = row_base_q + {8'd0, cols_q};
                src_addr_d = row_base_q + {8'd0, cols_q};
              end
            end else begin
              ky_d       = ky_q + 4'd1;
              src_addr_d = row_base_q;
            end
          end else begin
            c_d        = c_q + 6'd1;
            src_addr_d = src_addr_q + 14'd1;
          end
        end else begin
          kx_d = kx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    we_d   = (state_d == S_WRITE);
    done_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      k_q         <= '0;
      zero_q      <= 1'b0;
      row_base_q  <= '0;
      src_addr_q  <= src_start_address;
      dest_addr_q <= dest_start_address;
      data_q      <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b1;
      sy_q        <= '0;
      ky_q        <= '0;
      c_q         <= '0;
      kx_q        <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      k_q         <= k_d;
      zero_q      <= zero_d;
      row_base_q  <= row_base_d;
      src_addr_q  <= src_addr_d;
      dest_addr_q <= dest_addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      done_q      <= done_d;
      sy_q        <= sy_d;
      ky_q        <= ky_d;
      c_q         <= c_d;
      kx_q        <= kx_d;
    end
  end

  assign done           = done_q;
  assign src_address    = src_addr_q;
  assign src_write_en   = 1'b0;
  assign dest_address   = dest_addr_q;
  assign dest_writedata = data_q;
  assign dest_write_en  = we_q;

endmodule

// File: tb/tb_matrix_upsample.sv
// Directed bench for matrix_upsample: source RAM model, negedge write monitor,
// one task per scenario with hand-computed expectations.
module tb_matrix_upsample;

  logic               clk;
  logic               reset;
  logic               start;
  logic               done;
  logic [13:0]        src_start_address;
  logic [13:0]        src_address;
  logic signed [15:0] src_readdata;
  logic               src_write_en;
  logic [5:0]         src_row_size;
  logic [5:0]         src_col_size;
  logic [3:0]         scale;
  logic [13:0]        dest_start_address;
  logic [13:0]        dest_address;
  logic signed [15:0] dest_writedata;
  logic               dest_write_en;

  matrix_upsample dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .done               (done),
    .src_start_address  (src_start_address),
    .src_address        (src_address),
    .src_readdata       (src_readdata),
    .src_write_en       (src_write_en),
    .src_row_size       (src_row_size),
    .src_col_size       (src_col_size),
    .scale              (scale),
    .dest_start_address (dest_start_address),
    .dest_address       (dest_address),
    .dest_writedata     (dest_writedata),
    .dest_write_en      (dest_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] smem [0:16383];
  logic signed [15:0] dmem [0:16383];
  bit                 wr_seen [0:16383];
  int                 wr_count;
  int                 dup_count;
  int                 n_cmp;
  int                 n_bad;

  int exp_basic [16] = '{1, 1, -2, -2, 1, 1, -2, -2, 3, 3, 4, 4, 3, 3, 4, 4};

  always @(posedge clk) src_readdata <= smem[src_address];

  always @(negedge clk) begin
    if (dest_write_en === 1'b1) begin
      if (wr_seen[dest_address]) dup_count++;
      wr_seen[dest_address] = 1'b1;
      dmem[dest_address]    = dest_writedata;
      wr_count++;
    end
  end

  task automatic clear_dest();
    for (int i = 0; i < 16384; i++) begin
      wr_seen[i] = 1'b0;
      dmem[i]    = '0;
    end
    wr_count  = 0;
    dup_count = 0;
  endtask

  task automatic set_cfg(input int r, input int c, input int k, input int sa, input int da);
    src_row_size       = r[5:0];
    src_col_size       = c[5:0];
    scale              = k[3:0];
    src_start_address  = sa[13:0];
    dest_start_address = da[13:0];
  endtask

  // Pulses start and counts cycles (start cycle included) until done returns.
  task automatic run_op(input int max_cyc, output int cyc, output bit to);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    to  = (done !== 1'b1);
    cyc = n + 1;
  endtask

  task automatic load_basic_src();
    smem[0] = 16'sd1;
    smem[1] = -16'sd2;
    smem[2] = 16'sd3;
    smem[3] = 16'sd4;
  endtask

  task automatic test_reset();
    logic signed [15:0] e;
    set_cfg(2, 2, 2, 14'h0123, 14'h0456);
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL reset_done: got %b expected 1", done); end
    n_cmp++;
    if (dest_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", dest_write_en); end
    e = 16'sd0;
    n_cmp++;
    if (dest_writedata !== e) begin n_bad++; $display("FAIL reset_data: got %0d expected 0", dest_writedata); end
    n_cmp++;
    if (src_address !== 14'h0123) begin n_bad++; $display("FAIL reset_src_addr: got %h expected 0123", src_address); end
    n_cmp++;
    if (dest_address !== 14'h0456) begin n_bad++; $display("FAIL reset_dest_addr: got %h expected 0456", dest_address); end
    start = 1'b0;
    reset = 1'b0;
    src_start_address  = 14'h0200;
    dest_start_address = 14'h0777;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (src_address !== 14'h0200) begin n_bad++; $display("FAIL idle_src_track: got %h expected 0200", src_address); end
    n_cmp++;
    if (dest_address !== 14'h0777) begin n_bad++; $display("FAIL idle_dest_track: got %h expected 0777", dest_address); end
    n_cmp++;
    if (src_write_en !== 1'b0) begin n_bad++; $display("FAIL src_write_en: got %b expected 0", src_write_en); end
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    logic signed [15:0] e;
    load_basic_src();
    clear_dest();
    set_cfg(2, 2, 2, 14'h0000, 14'h0100);
    run_op(200, cyc, to);
    n_cmp++;
    if (to || cyc !== 41) begin n_bad++; $display("FAIL basic_cycles: got %0d (timeout=%0d) expected 41", cyc, to); end
    n_cmp++;
    if (wr_count !== 16) begin n_bad++; $display("FAIL basic_writes: got %0d expected 16", wr_count); end
    n_cmp++;
    if (dup_count !== 0) begin n_bad++; $display("FAIL basic_dup: got %0d expected 0", dup_count); end
    for (int i = 0; i < 16; i++) begin
      e = exp_basic[i][15:0];
      n_cmp++;
      if (!wr_seen[14'h100 + i] || dmem[14'h100 + i] !== e) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: got %0d (written=%0d) expected %0d", i, dmem[14'h100 + i], wr_seen[14'h100 + i], e);
      end
    end
  endtask

  task automatic test_identity();
    int cyc;
    bit to;
    logic signed [15:0] sv [9];
    sv[0] = 16'sh8000;
    sv[1] = 16'sh7FFF;
    for (int i = 2; i < 9; i++) sv[i] = 16'($urandom);
    for (int i = 0; i < 9; i++) smem[14'h200 + i] = sv[i];
    clear_dest();
    set_cfg(3, 3, 1, 14'h0200, 14'h0300);
    run_op(200, cyc, to);
    n_cmp++;
    if (to || cyc !== 37) begin n_bad++; $display("FAIL ident_cycles: got %0d (timeout=%0d) expected 37", cyc, to); end
    n_cmp++;
    if (wr_count !== 9) begin n_bad++; $display("FAIL ident_writes: got %0d expected 9", wr_count); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (!wr_seen[14'h300 + i] || dmem[14'h300 + i] !== sv[i]) begin
        n_bad++;
        $display("FAIL ident_data[%0d]: got %h expected %h", i, dmem[14'h300 + i], sv[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit to;
    logic [13:0] a [4];
    logic signed [15:0] e;
    a[0] = 14'h3FFE; a[1] = 14'h3FFF; a[2] = 14'h0000; a[3] = 14'h0001;
    e = 16'sd5;
    smem[14'h010] = e;
    clear_dest();
    set_cfg(1, 1, 2, 14'h0010, 14'h3FFE);
    run_op(200, cyc, to);
    n_cmp++;
    if (to || cyc !== 11) begin n_bad++; $display("FAIL wrap_cycles: got %0d (timeout=%0d) expected 11", cyc, to); end
    n_cmp++;
    if (wr_count !== 4) begin n_bad++; $display("FAIL wrap_writes: got %0d expected 4", wr_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (!wr_seen[a[i]] || dmem[a[i]] !== e) begin
        n_bad++;
        $display("FAIL wrap_data[%h]: got %0d (written=%0d) expected 5", a[i], dmem[a[i]], wr_seen[a[i]]);
      end
    end
  endtask

  task automatic test_degenerate();
    int cyc;
    bit to;
    logic signed [15:0] e;
    load_basic_src();
    clear_dest();
    set_cfg(2, 2, 0, 14'h0000, 14'h0100);
    run_op(50, cyc, to);
    n_cmp++;
    if (to || cyc !== 2) begin n_bad++; $display("FAIL k0_cycles: got %0d (timeout=%0d) expected 2", cyc, to); end
    n_cmp++;
    if (wr_count !== 0) begin n_bad++; $display("FAIL k0_writes: got %0d expected 0", wr_count); end
    set_cfg(0, 2, 2, 14'h0000, 14'h0100);
    run_op(50, cyc, to);
    n_cmp++;
    if (to || cyc !== 2) begin n_bad++; $display("FAIL r0_cycles: got %0d (timeout=%0d) expected 2", cyc, to); end
    n_cmp++;
    if (wr_count !== 0) begin n_bad++; $display("FAIL r0_writes: got %0d expected 0", wr_count); end
    e = -16'sd7;
    smem[14'h020] = e;
    clear_dest();
    set_cfg(1, 1, 12, 14'h0020, 14'h0080);
    run_op(500, cyc, to);
    n_cmp++;
    if (to || cyc !== 89) begin n_bad++; $display("FAIL k12_cycles: got %0d (timeout=%0d) expected 89", cyc, to); end
    n_cmp++;
    if (wr_count !== 64) begin n_bad++; $display("FAIL k12_writes: got %0d expected 64", wr_count); end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (!wr_seen[14'h080 + i] || dmem[14'h080 + i] !== e) begin
        n_bad++;
        $display("FAIL k12_data[%0d]: got %0d expected -7", i, dmem[14'h080 + i]);
      end
    end
  endtask

  task automatic test_abort();
    int cyc;
    int n;
    bit to;
    logic signed [15:0] e;
    load_basic_src();
    clear_dest();
    set_cfg(2, 2, 2, 14'h0000, 14'h0100);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (wr_count < 5 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (wr_count !== 5) begin n_bad++; $display("FAIL abort_reach5: got %0d expected 5", wr_count); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dest_write_en !== 1'b0) begin n_bad++; $display("FAIL abort_we: got %b expected 0", dest_write_en); end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL abort_done: got %b expected 1", done); end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_count !== 5 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_no_resume: got writes=%0d done=%b expected writes=5 done=1", wr_count, done);
    end
    clear_dest();
    run_op(200, cyc, to);
    n_cmp++;
    if (to || cyc !== 41) begin n_bad++; $display("FAIL abort_rerun_cycles: got %0d (timeout=%0d) expected 41", cyc, to); end
    n_cmp++;
    if (wr_count !== 16) begin n_bad++; $display("FAIL abort_rerun_writes: got %0d expected 16", wr_count); end
    for (int i = 0; i < 16; i++) begin
      e = exp_basic[i][15:0];
      n_cmp++;
      if (dmem[14'h100 + i] !== e) begin
        n_bad++;
        $display("FAIL abort_rerun_data[%0d]: got %0d expected %0d", i, dmem[14'h100 + i], e);
      end
    end
  endtask

  task automatic test_config_hold();
    int n;
    logic signed [15:0] e;
    load_basic_src();
    clear_dest();
    set_cfg(2, 2, 2, 14'h0000, 14'h0100);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    scale        = 4'd3;
    src_col_size = 6'd1;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      if (n == 12) start = 1'b1;
      if (n == 13) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || n + 1 !== 41) begin n_bad++; $display("FAIL hold_cycles: got %0d expected 41", n + 1); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_count !== 16 || dup_count !== 0) begin
      n_bad++;
      $display("FAIL hold_writes: got %0d (dup=%0d) expected 16 (dup=0)", wr_count, dup_count);
    end
    for (int i = 0; i < 16; i++) begin
      e = exp_basic[i][15:0];
      n_cmp++;
      if (dmem[14'h100 + i] !== e) begin
        n_bad++;
        $display("FAIL hold_data[%0d]: got %0d expected %0d", i, dmem[14'h100 + i], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_done [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int n;
    clear_dest();
    set_cfg(2, 2, 0, 14'h0000, 14'h0100);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (done !== exp_done[i]) begin
        n_bad++;
        $display("FAIL b2b_done[%0d]: got %b expected %b", i, done, exp_done[i]);
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    smem[14'h030] = 16'sd9;
    set_cfg(1, 1, 1, 14'h0030, 14'h0500);
    @(negedge clk);
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (wr_count !== 2 || dup_count !== 1) begin
      n_bad++;
      $display("FAIL b2b_writes: got writes=%0d repeats=%0d expected writes=2 repeats=1", wr_count, dup_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16384; i++) smem[i] = '0;
    clear_dest();
    test_reset();
    test_basic();
    test_identity();
    test_wrap();
    test_degenerate();
    test_abort();
    test_config_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
